// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start(0), data LSB first, [parity], stop(1).
// Optional even-parity bit enabled by defining SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    output logic             READY,
    output logic             SOUT,
    output logic             DONE
);
    localparam int DW = $clog2(DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    logic             r_par;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           r_state;
    logic [DW-1:0]    r_div;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shreg;
    logic             r_sout;
    logic             r_ready;
    logic             r_done;

    logic             w_bit_end;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_shnext;

    assign w_bit_end  = (r_div == DIV_LAST);
    assign w_last_bit = (r_bit == BIT_LAST);
    assign w_shnext   = r_shreg >> 1;

    assign SOUT  = r_sout;
    assign READY = r_ready;
    assign DONE  = r_done;

    // SOUT is loaded with the value of the state being entered, so it stays registered.
    always_ff @(posedge C) begin
        if (R) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_sout  <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (LOAD) begin
                        r_shreg <= DIN;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        r_par   <= ^DIN;
`endif
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= S_START;
                        r_sout  <= 1'b0;
                        r_ready <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_state <= S_DATA;
                        r_sout  <= r_shreg[0];
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_shreg <= w_shnext;
                        if (w_last_bit) begin
                            r_bit <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_sout  <= r_par;
`else
                            r_state <= S_STOP;
                            r_sout  <= 1'b1;
`endif
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            r_sout <= w_shnext[0];
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_state <= S_STOP;
                        r_sout  <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_state <= S_IDLE;
                        r_sout  <= 1'b1;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sout  <= 1'b1;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
